// File: rtl/can_pkg.sv
// +-----------------------------------------------------------------+
// | can_pkg : widths and depths shared across the CAN receive path   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package can_pkg;

   localparam int CAN_DATA_W        = 32;
   localparam int CAN_RX_FIFO_DEPTH = 8;

   // Pointer width carries one extra wrap bit so full and empty are distinguishable.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int CAN_RX_FIFO_PTR_W = ptr_w(CAN_RX_FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/can_fifo_ram.sv
// +-----------------------------------------------------------------+
// | can_fifo_ram : DEPTH x WIDTH store, sync write, async read       |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module can_fifo_ram
   import can_pkg::*;
#(
   parameter int DEPTH = CAN_RX_FIFO_DEPTH,
   parameter int WIDTH = CAN_DATA_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/can_rx_fifo.sv
// +-----------------------------------------------------------------+
// | can_rx_fifo : FWFT receive buffer behind the CAN frame register  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module can_rx_fifo
   import can_pkg::*;
#(
   parameter int DEPTH = CAN_RX_FIFO_DEPTH,
   parameter int WIDTH = CAN_DATA_W
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    write_fifo,
   input  logic [WIDTH-1:0]        send_data,
   input  logic                    read_en,
   output logic [WIDTH-1:0]        rdata,
   output logic                    empty,
   output logic                    full,
   output logic [ptr_w(DEPTH)-1:0] count,
   output logic                    overflow,
   output logic                    underflow,
   input  logic                    clear_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          wr_pend_q, wr_pend_d;
   logic          overflow_q, overflow_d;
   logic          pop, capture, drop;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign count     = wptr_q - rptr_q;
   assign underflow = read_en & empty;
   assign overflow  = overflow_q;

   // The frame register's data lags its strobe by one cycle, so captures
   // are keyed off the delayed strobe rather than write_fifo itself.
   always_comb begin
      wr_pend_d  = write_fifo;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      overflow_d = overflow_q;
      pop        = read_en & ~empty;
      capture    = wr_pend_q & (~full | pop);
      drop       = wr_pend_q & full & ~pop;

      if (capture) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clear_flags) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         wr_pend_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         wr_pend_q  <= wr_pend_d;
         overflow_q <= overflow_d;
      end
   end

   can_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (capture),
      .waddr (wptr_q[AW-1:0]),
      .wdata (send_data),
      .raddr (rptr_q[AW-1:0]),
      .rdata (rdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_can_rx_fifo.sv
// +-----------------------------------------------------------------+
// | tb_can_rx_fifo : directed self-checking bench for can_rx_fifo    |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_can_rx_fifo;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        write_fifo = 1'b0;
   logic [31:0] send_data = '0;
   logic        read_en = 1'b0;
   logic        clear_flags = 1'b0;
   logic [31:0] rdata;
   logic        empty, full, overflow, underflow;
   logic [3:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   can_rx_fifo #(.DEPTH(8), .WIDTH(32)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .write_fifo  (write_fifo),
      .send_data   (send_data),
      .read_en     (read_en),
      .rdata       (rdata),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .clear_flags (clear_flags)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pipelined strobes; word base+k follows the k-th strobe by one cycle.
   task automatic fill(input logic [31:0] base, input int n);
      for (int i = 0; i <= n; i++) begin
         write_fifo = (i < n);
         if (i > 0) send_data = base + 32'(i);
         tick();
      end
      write_fifo = 1'b0;
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      #2;
      n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      n_cmp++; if (count !== 4'd0)    begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
      n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %b want 0", underflow); end
      tick(); tick();
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_single_write;
      write_fifo = 1'b1;
      tick();
      write_fifo = 1'b0;
      send_data  = 32'hA5A5_0001;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_after_T got %b want 1", empty); end
      tick();
      n_cmp++; if (empty !== 1'b0)           begin n_err++; $display("FAIL single_empty_after_T1 got %b want 0", empty); end
      n_cmp++; if (rdata !== 32'hA5A5_0001)  begin n_err++; $display("FAIL single_rdata got %h want a5a50001", rdata); end
      n_cmp++; if (count !== 4'd1)           begin n_err++; $display("FAIL single_count got %0d want 1", count); end
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_drain_empty got %b want 1", empty); end
   endtask

   task automatic test_back_to_back;
      fill(32'h0, 8);
      n_cmp++; if (full !== 1'b1)  begin n_err++; $display("FAIL b2b_full got %b want 1", full); end
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL b2b_count got %0d want 8", count); end
      for (int k = 1; k <= 8; k++) begin
         n_cmp++; if (rdata !== 32'(k)) begin n_err++; $display("FAIL b2b_rdata[%0d] got %h want %h", k, rdata, 32'(k)); end
         read_en = 1'b1;
         tick();
      end
      read_en = 1'b0;
      n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL b2b_empty got %b want 1", empty); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow got %b want 0", overflow); end
   endtask

   task automatic test_overflow;
      fill(32'h10, 8);
      write_fifo = 1'b1;
      tick();
      write_fifo = 1'b0;
      send_data  = 32'hDEAD_BEEF;
      tick();
      n_cmp++; if (overflow !== 1'b1)    begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
      n_cmp++; if (count !== 4'd8)       begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
      n_cmp++; if (rdata !== 32'h11)     begin n_err++; $display("FAIL ovf_head got %h want 00000011", rdata); end
      tick();
      n_cmp++; if (overflow !== 1'b1)    begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      n_cmp++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   task automatic test_full_pop_capture;
      logic [31:0] exp [8];
      exp = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'h09};
      write_fifo = 1'b1;
      tick();
      write_fifo = 1'b0;
      send_data  = 32'h0000_0009;
      read_en    = 1'b1;
      tick();
      read_en    = 1'b0;
      n_cmp++; if (count !== 4'd8)    begin n_err++; $display("FAIL fpc_count got %0d want 8", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpc_overflow got %b want 0", overflow); end
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if (rdata !== exp[k]) begin n_err++; $display("FAIL fpc_rdata[%0d] got %h want %h", k, rdata, exp[k]); end
         read_en = 1'b1;
         tick();
      end
      read_en = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fpc_empty got %b want 1", empty); end
   endtask

   task automatic test_underflow_capture;
      write_fifo = 1'b1;
      tick();
      write_fifo = 1'b0;
      send_data  = 32'h1234_5678;
      read_en    = 1'b1;
      #1;
      n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_pulse got %b want 1", underflow); end
      tick();
      read_en = 1'b0;
      #1;
      n_cmp++; if (underflow !== 1'b0)       begin n_err++; $display("FAIL udf_clear got %b want 0", underflow); end
      n_cmp++; if (count !== 4'd1)           begin n_err++; $display("FAIL udf_count got %0d want 1", count); end
      n_cmp++; if (rdata !== 32'h1234_5678)  begin n_err++; $display("FAIL udf_rdata got %h want 12345678", rdata); end
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
   endtask

   task automatic test_reset_mid;
      fill(32'h20, 8);
      write_fifo = 1'b1;
      tick();
      write_fifo = 1'b0;
      send_data  = 32'hDEAD_0000;
      tick();
      read_en = 1'b1;
      repeat (5) tick();
      read_en = 1'b0;
      n_cmp++; if (count !== 4'd3)    begin n_err++; $display("FAIL rmid_pre_count got %0d want 3", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rmid_pre_overflow got %b want 1", overflow); end
      write_fifo = 1'b1;
      tick();
      write_fifo = 1'b0;
      send_data  = 32'hCAFE_F00D;
      n_rst      = 1'b0;
      #1;
      n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL rmid_empty got %b want 1", empty); end
      n_cmp++; if (count !== 4'd0)    begin n_err++; $display("FAIL rmid_count got %0d want 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rmid_overflow got %b want 0", overflow); end
      #1;
      n_rst = 1'b1;
      tick(); tick();
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_post_empty got %b want 1", empty); end
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rmid_post_count got %0d want 0", count); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_overflow();
      test_full_pop_capture();
      test_underflow_capture();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/can_rx_fifo.md
# can_rx_fifo

Receive-side buffer directly downstream of the CAN frame register. It accepts each accepted frame's 32-bit data word on the register's write strobe and holds it for the host/bus-interface side. Words are presented first-word-fall-through. Occupancy is reported, and overflow/underflow are flagged. Write capture is internally delayed one cycle, because the frame register asserts its write strobe one cycle before its data output becomes valid.

## Interface
Parameters:
- DEPTH, 8, number of 32-bit entries; power of two, >= 2
- WIDTH, 32, data word width; must equal the CAN data field width

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- write_fifo  in  1  write strobe from the frame register; the data qualified by it arrives one cycle later
- send_data  in  WIDTH  data word from the frame register; sampled one cycle after write_fifo
- read_en  in  1  host pop request
- rdata  out  WIDTH  head entry; valid whenever empty=0
- empty  out  1  no valid entries
- full  out  1  DEPTH valid entries
- count  out  $clog2(DEPTH)+1  number of valid entries
- overflow  out  1  sticky; a capture was dropped because the FIFO was full
- underflow  out  1  one-cycle pulse; read_en was high while empty
- clear_flags  in  1  clears overflow

## Operation
- wr_pend register: loads write_fifo every cycle. A capture occurs on an edge where wr_pend=1, storing send_data at wptr.
- Capture when not full, or when full and a pop occurs on the same edge: write mem[wptr], wptr++.
- Capture when full with no pop: word dropped, overflow<=1. Pointers and memory are unchanged.
- Pop when read_en=1 and empty=0: rptr++. No effect on memory.
- Pop attempt when empty: ignored; underflow=1 for that cycle (combinational, from read_en & empty).
- Capture and pop on the same edge:
  - When empty: capture only; the pop is ignored and underflow pulses.
  - Otherwise: both happen and count is unchanged.
- Pointers: $clog2(DEPTH)+1 bits with a wrap bit. Index is the low bits.
  - empty = (wptr==rptr)
  - full = index bits equal and wrap bits differ
  - count = wptr-rptr, modulo 2^($clog2(DEPTH)+1)
- rdata = mem[rptr index], combinational read. It is don't-care when empty, but must not be X after the first write.
- clear_flags=1: overflow<=0 on the next edge. If a drop occurs on the same edge, set wins.
- Reset values:
  - wptr=0, rptr=0, wr_pend=0
  - overflow=0, underflow=0
  - empty=1, full=0, count=0
  - memory contents not reset
- Reset mid-operation: a pending capture (wr_pend=1) is discarded and all stored words are lost.

## Timing
- Edge T: write_fifo=1 is sampled and wr_pend becomes 1.
- Edge T+1: send_data is captured. After T+1, empty=0 and rdata shows the word.
- Write-to-visible latency: 2 edges from write_fifo assertion.
- Back-to-back write_fifo pulses on consecutive cycles capture consecutive send_data values (pipelined, no bubble).
- Pop: with read_en high at edge P, rdata shows the next entry after P. Read-to-next latency is 1 edge.
- full/empty/count are registered-pointer derived: valid the cycle after the causing edge, with no combinational path from write_fifo or read_en.

## Structure
- Shared package can_pkg:
  - CAN_DATA_W=32
  - CAN_RX_FIFO_DEPTH=8
  - the pointer-width localparam function, so the frame register and host interface agree on widths
- One sub-module, can_fifo_ram: DEPTH x WIDTH storage.
  - Synchronous write: we, waddr, wdata.
  - Asynchronous read: raddr, rdata.
- Pointer, flag and wr_pend logic stay in can_rx_fifo.

## Test plan
- Reset, then write_fifo pulse with send_data=32'hA5A5_0001 the following cycle -> empty falls 2 edges after the pulse; rdata=32'hA5A5_0001, count=1.
- 8 pulses on consecutive cycles with data 1..8, then 8 pops -> rdata sequence 1..8; full=1 at count=8; empty=1 after the last pop; no overflow.
- Fill to 8, then capture 32'hDEAD_BEEF with no pop -> word dropped, overflow=1 and held, count=8; clear_flags -> overflow=0.
- Full, then capture 32'h0000_0009 coincident with a pop -> head advances, count stays 8, overflow=0; 9 is read out last.
- read_en while empty, simultaneously with a capture of 32'h1234_5678 -> underflow pulses one cycle; count=1, rdata=32'h1234_5678.
- n_rst asserted with wr_pend=1 and count=3 -> immediately empty=1, count=0, overflow=0; the pending word never appears after reset release.
